// File: rtl/axil_arbiter_rr_wr.sv
// Round-robin arbiter that shares one AXI-Lite slave write port among NUMBER_MASTER masters.
// Latency: grant appears 1 cycle after request; AW/W/B phases each close on the edge after their handshake.
// Backpressure: the grant is held until AW, W and B have all completed, and each of AW and W is gated after its handshake.
//
// Ports:
//   aclk, aresetn            clock, synchronous active-low reset
//   request_wr[N]            per-master write request (awvalid | wvalid)
//   m_axil_awvalid[N]        per-master AW valid
//   s_axil_awready           slave AW ready
//   m_axil_wvalid[N]         per-master W valid
//   s_axil_wready            slave W ready
//   s_axil_bvalid            slave B valid
//   m_axil_bready[N]         per-master B ready
//   grant_wr[N]              one-hot grant, zero when idle
//   grant_wr_cdr             binary index of the granted master, zero when idle
//   aw_en, w_en              AW / W channel open for the granted master
//   arb_busy                 a write transaction is in progress
module axil_arbiter_rr_wr #(
  parameter int NUMBER_MASTER = 4
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NUMBER_MASTER-1:0]         request_wr,
  input  logic [NUMBER_MASTER-1:0]         m_axil_awvalid,
  input  logic                             s_axil_awready,
  input  logic [NUMBER_MASTER-1:0]         m_axil_wvalid,
  input  logic                             s_axil_wready,
  input  logic                             s_axil_bvalid,
  input  logic [NUMBER_MASTER-1:0]         m_axil_bready,
  output logic [NUMBER_MASTER-1:0]         grant_wr,
  output logic [$clog2(NUMBER_MASTER)-1:0] grant_wr_cdr,
  output logic                             aw_en,
  output logic                             w_en,
  output logic                             arb_busy
);

  localparam int IDX_W = $clog2(NUMBER_MASTER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic [IDX_W-1:0]         rr_ptr, rr_ptr_nxt;
  logic                     aw_done, aw_done_nxt;
  logic                     w_done, w_done_nxt;
  logic [NUMBER_MASTER-1:0] grant_nxt;
  logic [IDX_W-1:0]         cdr_nxt;
  logic                     aw_en_nxt, w_en_nxt, busy_nxt;

  logic [IDX_W-1:0]         cand_idx;
  logic [IDX_W:0]           scan_idx;
  logic                     aw_hs, w_hs, b_hs;

  // Candidate search: walk offsets from the highest down so the smallest
  // offset from rr_ptr is the last (winning) assignment. The extra bit in
  // scan_idx keeps rr_ptr+offset from overflowing before the explicit wrap,
  // which is what makes non-power-of-two counts wrap at NUMBER_MASTER-1.
  always_comb begin
    cand_idx = '0;
    scan_idx = '0;
    for (int i = NUMBER_MASTER - 1; i >= 0; i--) begin
      scan_idx = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (scan_idx >= (IDX_W+1)'(NUMBER_MASTER))
        scan_idx = scan_idx - (IDX_W+1)'(NUMBER_MASTER);
      if (request_wr[scan_idx[IDX_W-1:0]])
        cand_idx = scan_idx[IDX_W-1:0];
    end
  end

  // Handshakes only count for the granted master and only while the channel is open.
  assign aw_hs = aw_en & m_axil_awvalid[grant_wr_cdr] & s_axil_awready;
  assign w_hs  = w_en & m_axil_wvalid[grant_wr_cdr] & s_axil_wready;
  assign b_hs  = s_axil_bvalid & m_axil_bready[grant_wr_cdr];

  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    grant_nxt   = grant_wr;
    cdr_nxt     = grant_wr_cdr;
    aw_en_nxt   = aw_en;
    w_en_nxt    = w_en;
    busy_nxt    = arb_busy;

    case (state)
      IDLE: begin
        if (|request_wr) begin
          grant_nxt           = '0;
          grant_nxt[cand_idx] = 1'b1;
          cdr_nxt             = cand_idx;
          aw_en_nxt           = 1'b1;
          w_en_nxt            = 1'b1;
          busy_nxt            = 1'b1;
          aw_done_nxt         = 1'b0;
          w_done_nxt          = 1'b0;
          state_nxt           = DATA;
        end
      end

      DATA: begin
        if (aw_hs) begin
          aw_done_nxt = 1'b1;
          aw_en_nxt   = 1'b0;
        end
        if (w_hs) begin
          w_done_nxt = 1'b1;
          w_en_nxt   = 1'b0;
        end
        // Handshakes landing this cycle count, so AW+W together go straight to RESP.
        if ((aw_done | aw_hs) & (w_done | w_hs))
          state_nxt = RESP;
      end

      RESP: begin
        aw_en_nxt = 1'b0;
        w_en_nxt  = 1'b0;
        if (b_hs) begin
          state_nxt    = IDLE;
          grant_nxt    = '0;
          cdr_nxt      = '0;
          busy_nxt     = 1'b0;
          rr_ptr_nxt   = (grant_wr_cdr == IDX_W'(NUMBER_MASTER - 1)) ? '0
                                                                       : grant_wr_cdr + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        cdr_nxt   = '0;
        aw_en_nxt = 1'b0;
        w_en_nxt  = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      grant_wr     <= '0;
      grant_wr_cdr <= '0;
      aw_en        <= 1'b0;
      w_en         <= 1'b0;
      arb_busy     <= 1'b0;
    end else begin
      state        <= state_nxt;
      rr_ptr       <= rr_ptr_nxt;
      aw_done      <= aw_done_nxt;
      w_done       <= w_done_nxt;
      grant_wr     <= grant_nxt;
      grant_wr_cdr <= cdr_nxt;
      aw_en        <= aw_en_nxt;
      w_en         <= w_en_nxt;
      arb_busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_axil_arbiter_rr_wr.sv
// Bench for the round-robin AXI-Lite write arbiter: one 4-master and one 3-master instance share stimulus.
// Outputs are compared every cycle against a transaction-level model (owner, owed phases, pointer).
// Directed sequences cover the listed scenarios, then randomized traffic with occasional resets.
module tb_axil_arbiter_rr_wr;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [3:0] req, awv, wv, br;
  logic       awr, wr, bv;

  logic [3:0] g4;
  logic [1:0] c4;
  logic       awe4, we4, busy4;
  logic [2:0] g3;
  logic [1:0] c3;
  logic       awe3, we3, busy3;

  int checks   = 0;
  int failures = 0;

  // Transaction-level reference: who owns the port, which phases are still owed, next start index.
  int m_owner [2];
  int m_ptr   [2];
  bit m_awl   [2];
  bit m_wl    [2];

  always #5 aclk = ~aclk;

  axil_arbiter_rr_wr #(.NUMBER_MASTER(4)) u_dut4 (
    .aclk(aclk), .aresetn(aresetn), .request_wr(req),
    .m_axil_awvalid(awv), .s_axil_awready(awr),
    .m_axil_wvalid(wv), .s_axil_wready(wr),
    .s_axil_bvalid(bv), .m_axil_bready(br),
    .grant_wr(g4), .grant_wr_cdr(c4), .aw_en(awe4), .w_en(we4), .arb_busy(busy4)
  );

  axil_arbiter_rr_wr #(.NUMBER_MASTER(3)) u_dut3 (
    .aclk(aclk), .aresetn(aresetn), .request_wr(req[2:0]),
    .m_axil_awvalid(awv[2:0]), .s_axil_awready(awr),
    .m_axil_wvalid(wv[2:0]), .s_axil_wready(wr),
    .s_axil_bvalid(bv), .m_axil_bready(br[2:0]),
    .grant_wr(g3), .grant_wr_cdr(c3), .aw_en(awe3), .w_en(we3), .arb_busy(busy3)
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step(input int k, input int n);
    bit aw_go, w_go;
    if (!aresetn) begin
      m_owner[k] = -1;
      m_ptr[k]   = 0;
      m_awl[k]   = 0;
      m_wl[k]    = 0;
    end else if (m_owner[k] < 0) begin
      for (int off = n - 1; off >= 0; off--)
        if (req[(m_ptr[k] + off) % n]) m_owner[k] = (m_ptr[k] + off) % n;
      if (m_owner[k] >= 0) begin
        m_awl[k] = 1;
        m_wl[k]  = 1;
      end
    end else if (m_awl[k] || m_wl[k]) begin
      aw_go = m_awl[k] && awv[m_owner[k]] && awr;
      w_go  = m_wl[k] && wv[m_owner[k]] && wr;
      if (aw_go) m_awl[k] = 0;
      if (w_go)  m_wl[k]  = 0;
    end else if (bv && br[m_owner[k]]) begin
      m_ptr[k]   = (m_owner[k] + 1) % n;
      m_owner[k] = -1;
    end
  endtask

  task automatic compare_all();
    int o4, o3;
    o4 = m_owner[0];
    o3 = m_owner[1];
    check("n4_grant", g4,    (o4 >= 0) ? (1 << o4) : 0);
    check("n4_cdr",   c4,    (o4 >= 0) ? o4 : 0);
    check("n4_aw_en", awe4,  (o4 >= 0 && m_awl[0]) ? 1 : 0);
    check("n4_w_en",  we4,   (o4 >= 0 && m_wl[0]) ? 1 : 0);
    check("n4_busy",  busy4, (o4 >= 0) ? 1 : 0);
    check("n3_grant", g3,    (o3 >= 0) ? (1 << o3) : 0);
    check("n3_cdr",   c3,    (o3 >= 0) ? o3 : 0);
    check("n3_aw_en", awe3,  (o3 >= 0 && m_awl[1]) ? 1 : 0);
    check("n3_w_en",  we3,   (o3 >= 0 && m_wl[1]) ? 1 : 0);
    check("n3_busy",  busy3, (o3 >= 0) ? 1 : 0);
  endtask

  // Inputs are applied at the falling edge; outputs are checked at the next falling edge.
  task automatic cyc();
    model_step(0, 4);
    model_step(1, 3);
    @(posedge aclk);
    @(negedge aclk);
    compare_all();
  endtask

  task automatic clr_inputs();
    req = '0; awv = '0; wv = '0; br = '0;
    awr = 1'b0; wr = 1'b0; bv = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    m_owner[0] = -1; m_owner[1] = -1;
    m_ptr[0] = 0;    m_ptr[1] = 0;
    m_awl[0] = 0;    m_awl[1] = 0;
    m_wl[0] = 0;     m_wl[1] = 0;
    clr_inputs();
    aresetn = 1'b0;
    @(negedge aclk);
    cyc();
    cyc();
    check("rst_grant", g4, 0);
    check("rst_busy", busy4, 0);
    aresetn = 1'b1;

    // Single request from master 2; AW and W together, then B.
    req = 4'b0100;
    cyc();
    check("t1_grant", g4, 4'b0100);
    check("t1_cdr", c4, 2);
    check("t1_aw_en", awe4, 1);
    req = '0; awv = 4'b0100; wv = 4'b0100; awr = 1'b1; wr = 1'b1;
    cyc();
    clr_inputs(); bv = 1'b1; br = 4'b0100;
    cyc();
    check("t1_release", g4, 0);
    clr_inputs(); req = 4'b1111;
    cyc();
    check("t1_next_ptr", c4, 3);
    clr_inputs(); awv = 4'b1111; wv = 4'b1111; awr = 1'b1; wr = 1'b1;
    cyc();
    clr_inputs(); bv = 1'b1; br = 4'b1111;
    cyc();

    // Master 1: AW first, W three cycles later; awvalid kept high afterwards.
    clr_inputs(); req = 4'b0010;
    cyc();
    check("t3_cdr", c4, 1);
    clr_inputs(); awv = 4'b0010; awr = 1'b1; wv = 4'b0010; wr = 1'b0;
    cyc();
    check("t3_aw_closed", awe4, 0);
    check("t3_w_open", we4, 1);
    cyc();
    cyc();
    check("t3_w_still_open", we4, 1);
    wr = 1'b1;
    cyc();
    check("t3_resp_w_en", we4, 0);
    check("t3_resp_busy", busy4, 1);
    clr_inputs(); bv = 1'b1; br = 4'b0010;
    cyc();

    // B during DATA is ignored; B with bready low holds the grant.
    clr_inputs(); req = 4'b0001;
    cyc();
    check("t4_cdr", c4, 0);
    clr_inputs(); bv = 1'b1; br = 4'b1111;
    cyc();
    cyc();
    check("t4_data_hold", awe4, 1);
    clr_inputs(); awv = 4'b0001; wv = 4'b0001; awr = 1'b1; wr = 1'b1;
    cyc();
    clr_inputs(); bv = 1'b1; br = 4'b1110;
    for (int i = 0; i < 3; i++) cyc();
    check("t4_b_wait", busy4, 1);
    br = 4'b0001;
    cyc();
    check("t4_b_release", busy4, 0);

    // Reset while master 3 waits in RESP.
    clr_inputs(); req = 4'b1000;
    cyc();
    clr_inputs(); awv = 4'b1000; wv = 4'b1000; awr = 1'b1; wr = 1'b1;
    cyc();
    clr_inputs(); aresetn = 1'b0;
    cyc();
    check("t6_rst_grant", g4, 0);
    check("t6_rst_cdr", c4, 0);
    aresetn = 1'b1; req = 4'b1000;
    cyc();
    check("t6_cdr", c4, 3);
    clr_inputs(); awv = 4'b1000; wv = 4'b1000; awr = 1'b1; wr = 1'b1;
    cyc();
    clr_inputs(); bv = 1'b1; br = 4'b1000;
    cyc();

    // Fairness with everything held high: 0,1,2,3,0 with an idle cycle between grants.
    req = 4'b1111; awv = 4'b1111; wv = 4'b1111; br = 4'b1111;
    awr = 1'b1; wr = 1'b1; bv = 1'b1;
    for (int g = 0; g < 5; g++) begin
      cnt = 0;
      while (g4 == 0 && cnt < 10) begin cyc(); cnt++; end
      check("fair_idx", c4, g % 4);
      cnt = 0;
      while (g4 != 0 && cnt < 10) begin cyc(); cnt++; end
      check("fair_gap", g4, 0);
    end

    // Randomized traffic with rare resets.
    for (int i = 0; i < 4000; i++) begin
      aresetn = ($urandom_range(0, 299) != 0);
      req     = 4'($urandom);
      awv     = 4'($urandom);
      wv      = 4'($urandom);
      br      = 4'($urandom);
      awr     = 1'($urandom);
      wr      = 1'($urandom);
      bv      = 1'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
